// File: rtl/parity_pkg.sv
// Shared FSM encoding and default frame constants for the parity frame receiver.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_ODD_PAR = 0;
    // Bit counter is sized for the widest supported frame (16 data bits).
    localparam int unsigned CNT_W       = 5;

endpackage

// File: rtl/parity_acc.sv
// Running parity accumulator: an xor gate feeding a single clear/enable flop.
module parity_acc (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic EN,
    input  logic D,
    output logic P
);

    logic r_p;
    logic w_sum;

    xor u_xor (w_sum, r_p, D);

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_p <= 1'b0;
        end else if (EN) begin
            r_p <= w_sum;
        end
    end

    assign P = r_p;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional saturating error counter on ERR_CNT when PARITY_FRAME_RX_ERR_CNT_EN is defined.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ODD_PAR = DEF_ODD_PAR
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SIN,
    input  logic              SVALID,
    output logic [DATA_W-1:0] DOUT,
    output logic              DVALID,
    output logic              PERR,
    output logic              FERR,
    output logic              BUSY
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    ,
    output logic [7:0]        ERR_CNT
`endif
);

    localparam logic L_ODD = (ODD_PAR != 0);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_dout;
    logic              r_mis;
    logic              r_dvalid;
    logic              r_perr;
    logic              r_ferr;
    logic              w_p;
    logic              w_start;
    logic              w_acc_en;
    logic              w_last_bit;
    logic              w_busy;

    parity_acc u_acc (
        .CLK (CLK),
        .RST (RST),
        .CLR (w_start),
        .EN  (w_acc_en),
        .D   (SIN),
        .P   (w_p)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (SVALID) begin
            case (r_state)
                ST_IDLE:   if (!SIN) w_next = ST_DATA;
                ST_DATA:   if (w_last_bit) w_next = ST_PARITY;
                ST_PARITY: w_next = ST_STOP;
                ST_STOP:   w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy     = (r_state != ST_IDLE);
        w_start    = SVALID && (r_state == ST_IDLE) && !SIN;
        w_acc_en   = SVALID && (r_state == ST_DATA);
        w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));
    end

    // Pulses are registered so they land one cycle after the stop-bit sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt    <= '0;
            r_shift  <= '0;
            r_dout   <= '0;
            r_mis    <= 1'b0;
            r_dvalid <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            if (w_start) begin
                r_cnt <= '0;
            end
            if (w_acc_en) begin
                for (int unsigned i = 0; i < DATA_W; i++) begin
                    if (r_cnt == CNT_W'(i)) r_shift[i] <= SIN;
                end
                r_cnt <= r_cnt + 1'b1;
            end
            if (SVALID && (r_state == ST_PARITY)) begin
                r_mis <= w_p ^ SIN ^ L_ODD;
            end
            if (SVALID && (r_state == ST_STOP)) begin
                if (SIN) begin
                    r_dout   <= r_shift;
                    r_dvalid <= 1'b1;
                    r_perr   <= r_mis;
                end else begin
                    r_ferr   <= 1'b1;
                end
            end
        end
    end

`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_cnt <= '0;
        end else if ((r_perr || r_ferr) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign ERR_CNT = r_err_cnt;
`endif

    assign DOUT   = r_dout;
    assign DVALID = r_dvalid;
    assign PERR   = r_perr;
    assign FERR   = r_ferr;
    assign BUSY   = w_busy;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed and randomized frames against a result scoreboard for parity_frame_rx.
module tb_parity_frame_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SIN = 1'b1;
    logic       SVALID = 1'b0;
    logic [7:0] DOUT;
    logic       DVALID;
    logic       PERR;
    logic       FERR;
    logic       BUSY;
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    logic [7:0] ERR_CNT;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // {DVALID, PERR, FERR, DOUT}
    logic [10:0] q_exp[$];
    logic [7:0]  exp_dout = 8'h00;

    parity_frame_rx #(.DATA_W(8), .ODD_PAR(0)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SIN     (SIN),
        .SVALID  (SVALID),
        .DOUT    (DOUT),
        .DVALID  (DVALID),
        .PERR    (PERR),
        .FERR    (FERR),
        .BUSY    (BUSY)
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
        ,
        .ERR_CNT (ERR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Every output pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (DVALID !== 1'b0 || FERR !== 1'b0 || PERR !== 1'b0) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_pulse", {21'd0, DVALID, PERR, FERR, DOUT}, 32'd0);
            end else begin
                chk("frame_result", {21'd0, DVALID, PERR, FERR, DOUT}, {21'd0, q_exp.pop_front()});
            end
        end
    end

    task automatic drive(input logic b, input int unsigned gap, input logic busy_exp);
        for (int unsigned g = 0; g < gap; g++) begin
            @(negedge CLK);
            chk("busy_gap", {31'd0, BUSY}, {31'd0, busy_exp});
            SVALID = 1'b0;
            SIN    = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        chk("busy", {31'd0, BUSY}, {31'd0, busy_exp});
        SVALID = 1'b1;
        SIN    = b;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int unsigned gap);
        logic mis;
        drive(1'b0, gap, 1'b0);
        for (int unsigned i = 0; i < 8; i++) drive(data[i], gap, 1'b1);
        drive(par, gap, 1'b1);
        drive(stop, gap, 1'b1);
        mis = (^data) ^ par;
        if (stop) begin
            q_exp.push_back({1'b1, mis, 1'b0, data});
            exp_dout = data;
        end else begin
            q_exp.push_back({1'b0, 1'b0, 1'b1, exp_dout});
        end
    endtask

    task automatic drain();
        @(negedge CLK);
        SVALID = 1'b0;
        SIN    = 1'b1;
        for (int unsigned c = 0; c < 20 && q_exp.size() != 0; c++) @(negedge CLK);
        chk("drain_pending", q_exp.size(), 32'd0);
        chk("dout_hold", {24'd0, DOUT}, {24'd0, exp_dout});
        chk("busy_idle", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST    = 1'b1;
        SVALID = 1'b1;
        SIN    = 1'b0;
        @(negedge CLK);
        chk("rst_outputs", {27'd0, DVALID, PERR, FERR, BUSY, 1'b0}, 32'd0);
        chk("rst_dout", {24'd0, DOUT}, 32'd0);
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
        chk("rst_err_cnt", {24'd0, ERR_CNT}, 32'd0);
`endif
        RST    = 1'b0;
        SVALID = 1'b0;
        SIN    = 1'b1;
        exp_dout = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        repeat (2) @(negedge CLK);
        do_reset();

        // Idle-level samples are ignored.
        for (int unsigned i = 0; i < 3; i++) drive(1'b1, 0, 1'b0);
        drain();

        send_frame(8'hA5, 1'b0, 1'b1, 0);
        drain();
        send_frame(8'h01, 1'b0, 1'b1, 0);
        drain();
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        drain();
        send_frame(8'hA5, 1'b0, 1'b1, 3);
        drain();

        // Aborted frame: start plus 4 data bits, then reset.
        drive(1'b0, 0, 1'b0);
        for (int unsigned i = 0; i < 4; i++) drive(1'b1, 0, 1'b1);
        do_reset();
        drain();
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        drain();

        // Back-to-back frames with no idle cycle in between.
        send_frame(8'hC3, 1'b1, 1'b1, 0);
        send_frame(8'h7E, 1'b0, 1'b1, 0);
        send_frame(8'h81, 1'b0, 1'b0, 0);
        drain();

        for (int unsigned n = 0; n < 20; n++) begin
            d = 8'($urandom);
            send_frame(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       $urandom_range(0, 2));
        end
        drain();

`ifdef PARITY_FRAME_RX_ERR_CNT_EN
        do_reset();
        for (int unsigned n = 0; n < 300; n++) begin
            d = 8'($urandom);
            send_frame(d, ~(^d), 1'b1, 0);
        end
        drain();
        chk("err_cnt_sat", {24'd0, ERR_CNT}, 32'd255);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
PARITY_FRAME_RX -- requirements
Module: PARITY_FRAME_RX

Interface
REQ-001 Parameter: DATA_W, default 8, number of data bits per frame (range 1..16).
REQ-002 Parameter: ODD_PAR, default 0; 0 = even parity, 1 = odd parity.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 SIN  input  1  serial line bit.
REQ-006 SVALID  input  1  SIN is sampled only in cycles where SVALID=1.
REQ-007 DOUT  output  DATA_W  last accepted data word.
REQ-008 DVALID  output  1  one-cycle pulse when DOUT is updated.
REQ-009 PERR  output  1  one-cycle pulse, coincident with DVALID, on parity mismatch.
REQ-010 FERR  output  1  one-cycle pulse on a stop-bit error; no DVALID in that cycle.
REQ-011 BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Frame format, in sample order: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: a sample of 0 moves to DATA, clears the bit counter, and clears the running parity; a sample of 1 is ignored.
REQ-015 DATA: each sample shifts into the data register at position bit-count and XORs into the running parity; after DATA_W samples, the FSM moves to PARITY.
REQ-016 PARITY: the mismatch flag is computed as (running parity XOR sample XOR ODD_PAR) != 0 and latched; the FSM moves to STOP.
REQ-017 STOP, sample=1: DOUT is loaded, DVALID=1 and PERR=mismatch flag in the next cycle, and the FSM returns to IDLE.
REQ-018 STOP, sample=0: FERR=1 in the next cycle, DOUT holds, DVALID=0, PERR=0, and the FSM returns to IDLE.
REQ-019 Latency: DVALID/PERR/FERR assert exactly one cycle after the CLK edge that samples the stop bit.
REQ-020 Cycles with SVALID=0 do not change any state; gaps of any length between samples are legal.
REQ-021 DOUT holds its value between accepted frames.
REQ-022 A start bit is accepted in the same cycle the FSM enters IDLE (no dead cycle after a stop bit).

Reset
REQ-023 RST=1 forces IDLE, bit counter=0, running parity=0, DOUT=0, DVALID=0, PERR=0, FERR=0, BUSY=0.
REQ-024 RST has priority over SVALID in the same cycle; reset mid-frame discards the partial frame without pulsing any output.

Configuration
REQ-025 Macro PARITY_FRAME_RX_ERR_CNT_EN, when defined, adds output ERR_CNT (8 bits).
- ERR_CNT increments on every PERR or FERR pulse.
- ERR_CNT saturates at 255.
- ERR_CNT is cleared by RST.
REQ-026 Without PARITY_FRAME_RX_ERR_CNT_EN, the ERR_CNT port and its counter logic are absent; all other behaviour is identical.

Structure
REQ-027 FSM state encodings (2-bit) and the default frame constants belong in shared package PARITY_PKG.
REQ-028 Running parity is a separate sub-module, PARITY_ACC.
- Inputs: CLK, RST, CLR, EN, D.
- Output: P.
- Implemented with an xor primitive feeding a 1-bit register.

Verification
REQ-029 Frame 0xA5, parity 0, stop 1, SVALID continuously high -> DOUT=0xA5, DVALID pulses for one cycle, PERR=0, FERR=0.
REQ-030 Frame 0x01, parity 0 (even mode) -> DOUT=0x01, DVALID=1 and PERR=1 in the same cycle.
REQ-031 Frame 0x5A, parity 0, stop 0 -> FERR pulses once, DVALID stays 0, DOUT keeps its previous value.
REQ-032 Frame 0xA5 with 3 SVALID=0 cycles between each bit -> result identical to REQ-029; BUSY stays high from the start bit through the stop bit.
REQ-033 RST asserted after 4 data bits, then a full frame 0x3C with parity 0 -> no pulses during the aborted frame; DOUT=0x3C, PERR=0.
REQ-034 With PARITY_FRAME_RX_ERR_CNT_EN defined, 300 frames with bad parity -> ERR_CNT=255; RST -> ERR_CNT=0.
